// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing the single-port 8x16 register file between two requesters.
// One command stage drives the RF strobes; reads return registered data two edges after grant.
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_rd,
    output logic              rf_wr,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_dout,
    output logic              busy
);

    // last_q: 0 = A granted last, 1 = B granted last
    logic              last_q, last_d;
    logic              vld_q, vld_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              rd_fire;

    always_comb begin
        gnt_a = rst_n & req_a & (~req_b | last_q);
        gnt_b = rst_n & req_b & (~req_a | ~last_q);

        last_d  = last_q;
        vld_d   = gnt_a | gnt_b;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (gnt_a) begin
            last_d  = 1'b0;
            port_d  = 1'b0;
            we_d    = we_a;
            addr_d  = addr_a;
            wdata_d = wdata_a;
        end else if (gnt_b) begin
            last_d  = 1'b1;
            port_d  = 1'b1;
            we_d    = we_b;
            addr_d  = addr_b;
            wdata_d = wdata_b;
        end

        // Read data is sampled at the end of the strobe cycle
        rd_fire    = vld_q & ~we_q;
        rvalid_a_d = rd_fire & ~port_q;
        rvalid_b_d = rd_fire & port_q;
        rdata_a_d  = rvalid_a_d ? rf_dout : rdata_a_q;
        rdata_b_d  = rvalid_b_d ? rf_dout : rdata_b_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            vld_q      <= 1'b0;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            last_q     <= last_d;
            vld_q      <= vld_d;
            port_q     <= port_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign rf_addr  = addr_q;
    assign rf_din   = wdata_q;
    assign rf_wr    = vld_q & we_q;
    assign rf_rd    = vld_q & ~we_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign busy     = vld_q | rvalid_a_q | rvalid_b_q;

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single-port 8 x 16-bit register file (`registers`: addr[2:0], rd, wr, data_in, data_out) between two requesters of the 16-bit processor. Port A is the writeback/execute side, port B the operand-fetch side. The block arbitrates round-robin, registers the winning command, drives the register-file strobes for exactly one cycle, and returns read data with a fixed latency. It sits between the control unit and the register file; nothing else drives the register file port.

## Interface
- DATA_W, 16, data width; must match the register file word.
- ADDR_W, 3, register address width; 8 registers, all addressable.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_a / req_b  in  1  request; held with its command fields stable until the matching gnt is seen high at a rising edge.
- we_a / we_b  in  1  1 = write, 0 = read.
- addr_a / addr_b  in  ADDR_W  register address.
- wdata_a / wdata_b  in  DATA_W  write data; ignored for reads.
- gnt_a / gnt_b  out  1  combinational grant; transfer happens on the edge where req and gnt are both 1.
- rvalid_a / rvalid_b  out  1  one-cycle pulse, read data valid.
- rdata_a / rdata_b  out  DATA_W  read data, registered, held until next read response on that port.
- rf_addr  out  ADDR_W  to register file addr.
- rf_rd  out  1  to register file rd.
- rf_wr  out  1  to register file wr.
- rf_din  out  DATA_W  to register file data_in.
- rf_dout  in  DATA_W  from register file data_out; combinational read of rf_addr while rf_rd=1.
- busy  out  1  command stage or response stage occupied.

## Operation
- Arbitration (combinational): only one requester -> grant it. Both -> grant the one not granted last (round-robin pointer `last`). Neither -> no grant.
- gnt_a and gnt_b are never both 1. gnt_x is never 1 without req_x.
- `last` updates only on a grant edge. Reset value is B, so A wins the first tie.
- Command stage (registers): on a grant edge, latch {valid=1, port, we, addr, wdata}. Otherwise valid=0. New commands are accepted every cycle, so there is no back-pressure beyond arbitration loss.
- RF drive: in the cycle after the grant edge, the block drives rf_addr and rf_din from the command stage. rf_wr = valid & we, rf_rd = valid & ~we. Each strobe is high for exactly one cycle per command, and never both in the same cycle. When idle, rf_rd and rf_wr are 0. rf_addr and rf_din hold their last values.
- Response stage: at the end of the RF-drive cycle, for a read, capture rf_dout into rdata_<port> and pulse rvalid_<port> for the following cycle. Writes produce no response.
- Ordering: commands complete in grant order. A read granted the edge after a write to the same address returns the new value, because the write strobe precedes the read strobe by one cycle.
- busy = command valid | any rvalid.

## Timing
- Grant edge = edge E. RF strobe is high in cycle E..E+1. rdata/rvalid are valid in cycle E+1..E+2. Read latency is 2 edges from grant.
- Throughput is one command per cycle across both ports combined. A requester holding req continuously against a continuous competitor gets every other cycle.
- Reset (rst_n=0 sampled at an edge): the following are cleared at that edge, and any in-flight command or response is dropped with no strobe and no rvalid afterwards:
  - gnt: 0 while rst_n=0.
  - rf_rd, rf_wr, rvalid_a/b, busy: 0.
  - rf_addr, rf_din, rdata_a/b: 0.
  - `last`: B.
- Requests are ignored while rst_n=0. Arbitration resumes on the first edge with rst_n=1.
- req dropped before grant: no effect, and the pointer is unchanged.

## Test plan
- Writes via A only: write r0=0x0001, r1=0x0002, r2=0x0001, r3=0x0003, r7=0x0005, one per cycle. Then B reads r0,r1,r2,r3,r7. Required: gnt each cycle, one rf_wr pulse per write, rdata_b = 1,2,1,3,5 with rvalid_b 2 edges after each grant.
- Tie from reset: req_a and req_b both high and held. Required: gnt_a first, then strict alternation A,B,A,B; rf_rd/rf_wr never both 1.
- Read-after-write hazard: A writes r4=0xBEEF on edge E, B reads r4 granted at E+1. Required: rdata_b=0xBEEF, rvalid_b in cycle E+2..E+3.
- Back-to-back reads on one port: A reads r1 and r2 in consecutive cycles. Required: two consecutive rvalid_a pulses; rdata_a=0x0002 then 0x0001.
- Reset mid-operation: grant a read of r3 at E, then rst_n=0 at E+1. Required: no rvalid, all outputs 0, busy=0. After release, a tie grants A first.
- Idle: no requests for 10 cycles. Required: gnt, rf_rd, rf_wr, rvalid and busy all 0, and rdata holds its last value.
